z80_wb_bus_master: RTL and testbench
====================================

Name: z80_wb_bus_master

Overview:
- Initiator-side bridge: converts asynchronous Z80 memory-bus cycles (MREQ_n/RD_n/WR_n) into single pipelined Wishbone transactions toward the memory adapter.
- Stretches the Z80 cycle with WAIT_n until the Wishbone ack returns, then drives read data back onto the Z80 data bus.
- Bounds every transaction with a timeout so a silent slave cannot hang the CPU.

Parameters:
- ADDR_WIDTH, 16, Z80/Wishbone address width
- DATA_WIDTH, 8, data width
- SYNC_STAGES, 2, flip-flop stages on MREQ_n/RD_n/WR_n (min 2)
- TIMEOUT_CYCLES, 255, i_clk cycles from strobe to forced abort
- TIMEOUT_WIDTH, 8, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
- i_clk  in  1  system clock; the only clock
- i_reset  in  1  asynchronous, active-high reset
- i_z80_mreq_n  in  1  Z80 memory request, async
- i_z80_rd_n  in  1  Z80 read strobe, async
- i_z80_wr_n  in  1  Z80 write strobe, async
- i_z80_addr  in  ADDR_WIDTH  Z80 address bus
- i_z80_data  in  DATA_WIDTH  Z80 write data
- o_z80_data  out  DATA_WIDTH  read data to Z80
- o_z80_data_oe  out  1  drive enable for o_z80_data
- o_z80_wait_n  out  1  Z80 WAIT_n (low = stretch)
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls
- o_wb_addr  out  ADDR_WIDTH  Wishbone address
- o_wb_data  out  DATA_WIDTH  Wishbone write data
- i_wb_ack, i_wb_stall  in  1 each  Wishbone slave responses
- i_wb_data  in  DATA_WIDTH  Wishbone read data
- o_bus_error  out  1  sticky timeout flag

Behaviour:
- Reset: one clock (i_clk). i_reset is asynchronous and active-high.
- Reset values: all outputs 0 except o_z80_wait_n=1. Also: state IDLE, synchronizers at 1 (inactive), armed=0.
- Synchronization: MREQ_n, RD_n and WR_n pass through SYNC_STAGES flops before use.
  - Address and data are sampled directly when a start is detected. They are stable because the Z80 holds them while MREQ_n is low.
- Arming: after reset, no start is accepted until synchronized MREQ_n has been seen high once. This prevents acting on a half-seen cycle when reset is released mid-cycle.
- Start condition, checked in IDLE with armed=1: synchronized MREQ_n=0 and exactly one of RD_n/WR_n low.
  - Both RD_n and WR_n low: ignored.
  - Refresh (MREQ_n low, RD_n and WR_n high): ignored.
- IDLE -> REQ on start, registered next edge:
  - cyc=1, stb=1, we=!WR_n.
  - addr and data latched.
  - wait_n=0, timeout counter cleared.
- REQ: hold stb and all request fields while i_wb_stall=1.
  - On a cycle with stall=0, drop stb next edge and go to ACK.
  - If i_wb_ack=1 in that same cycle, go directly to DONE, taking the ACK actions below.
- ACK: wait for i_wb_ack. On ack:
  - cyc=0.
  - For a read, latch i_wb_data into o_z80_data.
  - Go to DONE.
  - An ack while stb is still stalled in REQ is treated the same way.
- Timeout: the counter increments every cycle in REQ or ACK.
  - When it reaches TIMEOUT_CYCLES with no ack: cyc=0, stb=0.
  - For a read, o_z80_data=8'hFF.
  - o_bus_error=1 (sticky until reset). Go to DONE.
- DONE:
  - wait_n=1.
  - o_z80_data_oe=1 for reads only.
  - Stay until synchronized MREQ_n=1, then oe=0 and go to IDLE.
  - Back-to-back Z80 cycles need MREQ_n high between them, so exactly one Wishbone transaction is issued per Z80 cycle.
- Exactly one transaction is outstanding at any time. cyc stays high from REQ entry until the ack/timeout edge.
- Reset mid-transaction: cyc, stb and oe drop asynchronously, wait_n goes to 1, and the transaction is abandoned. The slave must tolerate a cyc drop.
- Clocking requirement: i_clk ≥ 4x the Z80 clock, so that WAIT_n falls before the Z80 samples it in T2.

Decomposition:
- Shared package z80_wb_pkg:
  - state enum {IDLE, REQ, ACK, DONE}
  - constant TIMEOUT_FILL = 8'hFF
- One sub-module, bus_sync: a parameterised N-stage synchronizer with reset value 1. Instantiate it once per control strobe.

Test Plan:
- Read, slave acks with no stall:
  - Stimulus: MREQ_n=0, RD_n=0, addr=16'h0123; slave returns 8'h5A with ack one cycle after stb.
  - Required: stb high exactly 1 cycle with we=0; wait_n low until ack+1; then o_z80_data=8'h5A and oe=1; oe=0 two cycles after MREQ_n rises.
- Write with stall:
  - Stimulus: WR_n=0, addr=16'h8000, data=8'hC3; i_wb_stall=1 for 3 cycles.
  - Required: stb held 4 cycles, addr/data/we constant throughout; exactly one transaction; oe never asserts.
- Timeout:
  - Stimulus: read of 16'hB000; slave never acks.
  - Required: after 255 cycles cyc=0, o_z80_data=8'hFF, o_bus_error=1, wait_n=1; the flag persists across a later good cycle.
- Reset mid-transaction:
  - Stimulus: assert i_reset in ACK, release it while MREQ_n is still low.
  - Required: cyc=0 and wait_n=1 immediately; no new stb until MREQ_n goes high, then low again.
- Illegal strobes:
  - Stimulus: MREQ_n low with RD_n and WR_n both low, and separately a refresh cycle.
  - Required: cyc stays 0 and wait_n stays 1.
- Ack in the stall-release cycle:
  - Stimulus: a read where stall=0 and ack=1 arrive in the same cycle.
  - Required: the state goes REQ -> DONE directly and data is latched.

Source files
------------

// File: rtl/z80_wb_pkg.sv
// Shared types for the Z80 to Wishbone initiator bridge.
// State encoding and the read value returned on a timed-out cycle.
package z80_wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK,
    DONE
  } state_t;

  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

endpackage

// File: rtl/z80_wb_bus_sync.sv
// N-stage synchronizer for an active-low asynchronous strobe.
// Resets to 1 so the strobe reads as inactive after reset.
module bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/z80_wb_bus_master.sv
// Z80 memory cycle to single Wishbone transaction bridge.
// Holds WAIT_n low until ack or timeout, then returns read data.
module z80_wb_bus_master
  import z80_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_z80_mreq_n,
  input  logic                  i_z80_rd_n,
  input  logic                  i_z80_wr_n,
  input  logic [ADDR_WIDTH-1:0] i_z80_addr,
  input  logic [DATA_WIDTH-1:0] i_z80_data,
  output logic [DATA_WIDTH-1:0] o_z80_data,
  output logic                  o_z80_data_oe,
  output logic                  o_z80_wait_n,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  output logic                  o_bus_error
);

  localparam logic [TIMEOUT_WIDTH-1:0] T_LAST =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state;
  logic                     armed;
  logic [SYNC_STAGES-1:0]   prime;
  logic [TIMEOUT_WIDTH-1:0] timer;
  logic                     mreq_s;
  logic                     rd_s;
  logic                     wr_s;
  logic                     start;

  bus_sync #(.STAGES(SYNC_STAGES)) u_sync_mreq (
    .clk(i_clk), .rst(i_reset), .d(i_z80_mreq_n), .q(mreq_s)
  );
  bus_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(i_clk), .rst(i_reset), .d(i_z80_rd_n), .q(rd_s)
  );
  bus_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(i_clk), .rst(i_reset), .d(i_z80_wr_n), .q(wr_s)
  );

  assign start = armed && !mreq_s && (rd_s ^ wr_s);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      armed         <= 1'b0;
      prime         <= '0;
      timer         <= '0;
      o_z80_data    <= '0;
      o_z80_data_oe <= 1'b0;
      o_z80_wait_n  <= 1'b1;
      o_wb_cyc      <= 1'b0;
      o_wb_stb      <= 1'b0;
      o_wb_we       <= 1'b0;
      o_wb_addr     <= '0;
      o_wb_data     <= '0;
      o_bus_error   <= 1'b0;
    end else begin
      // Synchronizer outputs only reflect the pins once their reset fill has drained.
      prime <= {prime[SYNC_STAGES-2:0], 1'b1};
      if (prime[SYNC_STAGES-1] && mreq_s) armed <= 1'b1;

      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= REQ;
            o_wb_cyc     <= 1'b1;
            o_wb_stb     <= 1'b1;
            o_wb_we      <= !wr_s;
            o_wb_addr    <= i_z80_addr;
            o_wb_data    <= i_z80_data;
            o_z80_wait_n <= 1'b0;
            timer        <= '0;
          end
        end
        REQ, ACK: begin
          timer <= timer + TIMEOUT_WIDTH'(1);
          if (i_wb_ack) begin
            state         <= DONE;
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_z80_wait_n  <= 1'b1;
            o_z80_data_oe <= !o_wb_we;
            if (!o_wb_we) o_z80_data <= i_wb_data;
          end else if (timer == T_LAST) begin
            state         <= DONE;
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_z80_wait_n  <= 1'b1;
            o_z80_data_oe <= !o_wb_we;
            o_bus_error   <= 1'b1;
            if (!o_wb_we) o_z80_data <= DATA_WIDTH'(TIMEOUT_FILL);
          end else if (state == REQ && !i_wb_stall) begin
            state    <= ACK;
            o_wb_stb <= 1'b0;
          end
        end
        DONE: begin
          if (mreq_s) begin
            state         <= IDLE;
            o_z80_data_oe <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_wb_bus_master.sv
// Randomized bench for z80_wb_bus_master with a per-transaction
// cycle-count model of the Z80 and Wishbone sides.
module tb_z80_wb_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mreq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [15:0] z_addr = '0;
  logic [7:0]  z_wdata = '0;
  logic [7:0]  z_rdata;
  logic        z_oe;
  logic        wait_n;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] wb_addr;
  logic [7:0]  wb_wdata;
  logic        ack = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  wb_rdata = '0;
  logic        bus_err;

  int n_chk = 0;
  int n_pass = 0;
  int txn = 0;
  int cyc_cnt = 0;
  int wlo_cnt = 0;
  logic stb_prev = 1'b0;
  bit err_m = 1'b0;

  z80_wb_bus_master dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_z80_mreq_n(mreq_n),
    .i_z80_rd_n(rd_n),
    .i_z80_wr_n(wr_n),
    .i_z80_addr(z_addr),
    .i_z80_data(z_wdata),
    .o_z80_data(z_rdata),
    .o_z80_data_oe(z_oe),
    .o_z80_wait_n(wait_n),
    .o_wb_cyc(cyc),
    .o_wb_stb(stb),
    .o_wb_we(we),
    .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata),
    .i_wb_ack(ack),
    .i_wb_stall(stall),
    .i_wb_data(wb_rdata),
    .o_bus_error(bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (stb && !stb_prev) txn <= txn + 1;
    if (cyc) cyc_cnt <= cyc_cnt + 1;
    if (!wait_n) wlo_cnt <= wlo_cnt + 1;
    stb_prev <= stb;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_txn(input bit wr, input logic [15:0] a,
                        input logic [7:0] d, input int stall_n,
                        input int ack_lat, input bit no_ack,
                        input logic [7:0] rdv);
    int  k, cyc_n, stb_n, wlo_n, t0, ackk, exp_cyc;
    bit  hold_ok, got_stb;
    t0 = txn;
    @(negedge clk);
    z_addr = a; z_wdata = d;
    mreq_n = 1'b0; rd_n = wr; wr_n = !wr;
    got_stb = 1'b0;
    for (int i = 0; i < 12 && !got_stb; i++) begin
      @(negedge clk);
      got_stb = stb;
    end
    chk("stb_start", 32'(got_stb), 32'd1);
    if (got_stb) begin
      ackk = no_ack ? 1000 : stall_n + ack_lat;
      k = 0; cyc_n = 0; stb_n = 0; wlo_n = 0; hold_ok = 1'b1;
      while (cyc && k < 300) begin
        cyc_n++;
        if (stb) begin
          stb_n++;
          if (wb_addr !== a || we !== wr || (wr && wb_wdata !== d))
            hold_ok = 1'b0;
        end
        if (!wait_n) wlo_n++;
        stall = (k < stall_n);
        ack = (k == ackk);
        wb_rdata = (k == ackk) ? rdv : 8'($urandom);
        @(negedge clk);
        k++;
      end
      stall = 1'b0; ack = 1'b0;
      exp_cyc = no_ack ? 255 : ackk + 1;
      if (no_ack) err_m = 1'b1;
      chk("cyc_len", 32'(cyc_n), 32'(exp_cyc));
      chk("stb_len", 32'(stb_n), 32'(stall_n + 1));
      chk("wait_lo_len", 32'(wlo_n), 32'(exp_cyc));
      chk("req_hold", 32'(hold_ok), 32'd1);
      chk("done_wait_n", 32'(wait_n), 32'd1);
      chk("done_oe", 32'(z_oe), 32'(!wr));
      if (!wr)
        chk("rd_data", 32'(z_rdata), no_ack ? 32'hFF : 32'(rdv));
      chk("bus_err", 32'(bus_err), 32'(err_m));
    end
    repeat (3) @(negedge clk);
    chk("one_txn", 32'(txn - t0), 32'd1);
    chk("oe_held", 32'(z_oe), 32'(!wr));
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("oe_release", 32'(z_oe), 32'd0);
    chk("idle_wait_n", 32'(wait_n), 32'd1);
  endtask

  initial begin
    int t0, c0, w0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_wait_n", 32'(wait_n), 32'd1);
    chk("rst_oe", 32'(z_oe), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_addr", 32'(wb_addr), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_txn(1'b0, 16'h0123, 8'h00, 0, 1, 1'b0, 8'h5A);
    do_txn(1'b1, 16'h8000, 8'hC3, 3, 1, 1'b0, 8'h00);
    do_txn(1'b0, 16'h4242, 8'h00, 2, 0, 1'b0, 8'h99);

    t0 = txn; c0 = cyc_cnt; w0 = wlo_cnt;
    @(negedge clk);
    mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (10) @(negedge clk);
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("both_low_txn", 32'(txn - t0), 32'd0);
    chk("both_low_cyc", 32'(cyc_cnt - c0), 32'd0);
    chk("both_low_wait", 32'(wlo_cnt - w0), 32'd0);
    mreq_n = 1'b0;
    repeat (10) @(negedge clk);
    mreq_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("refresh_txn", 32'(txn - t0), 32'd0);
    chk("refresh_cyc", 32'(cyc_cnt - c0), 32'd0);
    chk("refresh_wait", 32'(wlo_cnt - w0), 32'd0);

    do_txn(1'b0, 16'hB000, 8'h00, 1, 0, 1'b1, 8'h00);
    do_txn(1'b0, 16'h1234, 8'h00, 0, 2, 1'b0, 8'h3C);

    for (int n = 0; n < 16; n++)
      do_txn(1'($urandom), 16'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0), 8'($urandom));

    @(negedge clk);
    z_addr = 16'h7777; mreq_n = 1'b0; rd_n = 1'b0;
    c0 = 0;
    while (!stb && c0 < 12) begin
      @(negedge clk);
      c0++;
    end
    chk("rst_tx_stb", 32'(stb), 32'd1);
    @(negedge clk);
    chk("rst_tx_in_ack", 32'({cyc, stb}), 32'b10);
    rst = 1'b1;
    #1;
    chk("async_cyc", 32'(cyc), 32'd0);
    chk("async_wait_n", 32'(wait_n), 32'd1);
    chk("async_err", 32'(bus_err), 32'd0);
    err_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    t0 = txn; w0 = wlo_cnt;
    repeat (12) @(negedge clk);
    chk("no_restart_txn", 32'(txn - t0), 32'd0);
    chk("no_restart_wait", 32'(wlo_cnt - w0), 32'd0);
    mreq_n = 1'b1; rd_n = 1'b1;
    repeat (4) @(negedge clk);
    do_txn(1'b0, 16'h2468, 8'h00, 1, 1, 1'b0, 8'hE7);
    do_txn(1'b1, 16'hFFFF, 8'h81, 0, 0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
